// File: rtl/bar_ram_pkg.sv
// Shared types and constants for the BAR2 RAM port-A request sequencer.
package bar_ram_pkg;

  // Cycles from a port-A read issue until ram_douta carries the data.
  localparam int unsigned RAM_RD_LAT = 2;

  // Tag width carried in the read-data FIFO entry; the top's TAG_WIDTH must match.
  localparam int unsigned RD_TAG_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  typedef struct packed {
    logic [127:0]              data;
    logic [RD_TAG_WIDTH-1:0]   tag;
    logic                      last;
  } rd_entry_t;

endpackage

// File: rtl/rd_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module rd_fifo_fwft #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next pointer/count values; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop_i)  rptr_d = rptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset since empty_o qualifies the output.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/bar_ram_access.sv
// Port-A request sequencer for the BAR2 128-bit RAM: turns tagged burst
// requests into per-beat RAM accesses and buffers read data behind a
// credit-limited FWFT FIFO so downstream backpressure never drops a beat.
module bar_ram_access
  import bar_ram_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH / 4),
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_WIDTH  = RD_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [127:0]          wr_data,
  input  logic [15:0]           wr_strb,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [127:0]          rd_data,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic                  rd_last,
  output logic                  ram_ena,
  output logic [15:0]           ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [127:0]          ram_dina,
  input  logic [127:0]          ram_douta,
  output logic                  busy
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LAST_STG = RAM_RD_LAT - 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            rem_q, rem_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;

  logic [RAM_RD_LAT-1:0] pv_q, pv_d;
  logic [RAM_RD_LAT-1:0] pl_q, pl_d;
  logic [TAG_WIDTH-1:0]  pt_q [RAM_RD_LAT];
  logic [TAG_WIDTH-1:0]  pt_d [RAM_RD_LAT];

  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [127:0]          din_hold_q, din_hold_d;

  logic                  wr_beat, rd_issue, credit_ok;
  logic [CNT_W-1:0]      inflight, fifo_cnt;
  logic                  fifo_empty, fifo_push, fifo_pop;
  rd_entry_t             push_e, pop_e;

  // Read credit: issued-but-unpushed beats plus buffered beats must fit the FIFO.
  assign credit_ok = ((inflight + fifo_cnt) < CNT_W'(FIFO_DEPTH));

  // Burst FSM next-state and handshakes; rst gates accesses so a reset
  // cycle never touches the RAM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    tag_d     = tag_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          rem_d   = req_len;
          tag_d   = req_tag;
          state_d = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = !rst;
        wr_beat  = wr_valid && !rst;
        if (wr_beat) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - 4'd1;
          if (rem_q == 4'd0) state_d = IDLE;
        end
      end
      READ: begin
        rd_issue = credit_ok && !rst;
        if (rd_issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - 4'd1;
          if (rem_q == 4'd0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-latency tracking pipeline and in-flight count.
  always_comb begin
    pv_d[0] = rd_issue;
    pl_d[0] = rd_issue && (rem_q == 4'd0);
    pt_d[0] = tag_q;
    for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
    inflight = '0;
    for (int unsigned i = 0; i < RAM_RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pv_q[i]);
    end
  end

  // Port-A drive; address and write data hold their last value between accesses.
  always_comb begin
    ram_ena     = wr_beat | rd_issue;
    ram_wea     = wr_beat ? wr_strb : '0;
    ram_addra   = ram_ena ? addr_q : addr_hold_q;
    ram_dina    = wr_beat ? wr_data : din_hold_q;
    addr_hold_d = ram_addra;
    din_hold_d  = ram_dina;
  end

  // All sequencer state; reset discards any burst and in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      pv_q        <= '0;
      pl_q        <= '0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
      for (int unsigned i = 0; i < RAM_RD_LAT; i++) pt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      tag_q       <= tag_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
      for (int unsigned i = 0; i < RAM_RD_LAT; i++) pt_q[i] <= pt_d[i];
    end
  end

  // FIFO push from the final pipeline stage, pop on downstream handshake.
  always_comb begin
    fifo_push   = pv_q[LAST_STG];
    push_e.data = ram_douta;
    push_e.tag  = pt_q[LAST_STG];
    push_e.last = pl_q[LAST_STG];
    rd_valid    = !fifo_empty;
    fifo_pop    = rd_valid && rd_ready;
    rd_data     = rd_valid ? pop_e.data : '0;
    rd_tag      = rd_valid ? pop_e.tag  : '0;
    rd_last     = rd_valid && pop_e.last;
    busy        = (state_q != IDLE) || (|pv_q) || !fifo_empty;
  end

  rd_fifo_fwft #(
    .WIDTH ($bits(rd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (push_e),
    .pop_i   (fifo_pop),
    .dout_o  (pop_e),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_bar_ram_access.sv
// Directed bench for bar_ram_access with a behavioural RAM and a burst-level
// reference model of memory contents and expected read beats.
module tb_bar_ram_access;

  logic         clk, rst;
  logic         req_valid, req_ready, req_we;
  logic [7:0]   req_addr;
  logic [3:0]   req_len;
  logic [7:0]   req_tag;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic         rd_valid, rd_ready, rd_last;
  logic [127:0] rd_data;
  logic [7:0]   rd_tag;
  logic         ram_ena;
  logic [15:0]  ram_wea;
  logic [7:0]   ram_addra;
  logic [127:0] ram_dina, ram_douta;
  logic         busy;

  bar_ram_access #(
    .RAM_DEPTH  (1024),
    .ADDR_WIDTH (8),
    .FIFO_DEPTH (4),
    .TAG_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_tag   (req_tag),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_last   (rd_last),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural dual-register RAM: data two edges after the issue.
  logic [127:0] ram [256];
  logic [127:0] ram_r1;
  always @(posedge clk) begin
    if (ram_ena) begin
      for (int b = 0; b < 16; b++)
        if (ram_wea[b]) ram[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
      ram_r1 <= ram[ram_addra];
    end
    ram_douta <= ram_r1;
  end

  // Reference model: memory contents and queue of read beats still owed.
  typedef struct {
    logic [127:0] data;
    logic [7:0]   tag;
    logic         last;
  } beat_t;

  logic [127:0] mdl [256];
  beat_t        exp_q [$];
  logic [7:0]   addr_log [$];

  int checks = 0;
  int fails  = 0;
  int pops   = 0;
  int issue_cnt = 0;
  logic [127:0] last_data;
  logic         last_last;
  int unsigned  hs_cyc = 0;
  int unsigned  lat_meas = 0;
  logic         lat_armed = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] seed, input int i);
    return {4{seed + 32'(i)}};
  endfunction

  // Per-cycle observer: logs port-A accesses and checks every read beat taken.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_ena) begin
        addr_log.push_back(ram_addra);
        if (ram_wea == '0) issue_cnt++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rd_unexpected act=%h exp=none", rd_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_tag", rd_tag, e.tag);
          chk("rd_last", rd_last, e.last);
          last_data = rd_data;
          last_last = rd_last;
          pops++;
        end
      end
      if (lat_armed && rd_valid) begin
        lat_meas  = cyc - hs_cyc;
        lat_armed = 1'b0;
      end
    end
  end

  // Present a request; on handshake, reads enqueue their expected beats.
  task automatic send_req(input logic we, input logic [7:0] a, input logic [3:0] len,
                          input logic [7:0] tag);
    int n = 0;
    req_we = we; req_addr = a; req_len = len; req_tag = tag; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin n++; @(negedge clk); end
    if (!req_ready) begin
      checks++; fails++;
      $display("FAIL req_timeout act=0 exp=1");
    end else begin
      hs_cyc = cyc + 1;
      if (!we) begin
        for (int i = 0; i <= int'(len); i++) begin
          beat_t b;
          logic [7:0] ai;
          ai     = a + 8'(i);
          b.data = mdl[ai];
          b.tag  = tag;
          b.last = (i == int'(len));
          exp_q.push_back(b);
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [7:0] a, input logic [3:0] len,
                          input logic [31:0] seed, input logic [15:0] strb);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      logic [7:0] ai;
      ai = a + 8'(i);
      wr_valid = 1'b1; wr_data = mk(seed, i); wr_strb = strb;
      @(negedge clk);
      while (!wr_ready && n < 200) begin n++; @(negedge clk); end
      if (!wr_ready) begin
        checks++; fails++;
        $display("FAIL wr_timeout act=0 exp=1");
      end else begin
        for (int b = 0; b < 16; b++)
          if (strb[b]) mdl[ai][b*8 +: 8] = wr_data[b*8 +: 8];
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] len, input logic [31:0] seed,
                          input logic [15:0] strb, input logic [7:0] tag);
    send_req(1'b1, a, len, tag);
    wr_burst(a, len, seed, strb);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 500) begin n++; @(negedge clk); end
    if (exp_q.size() != 0 || busy) begin
      checks++; fails++;
      $display("FAIL idle_timeout act=%0d exp=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_a [4];
    int p0, n;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; mdl[i] = '0; end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_tag = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_tag", rd_tag, 8'h00);
    chk("rst_ram_ena", ram_ena, 1'b0);
    chk("rst_ram_wea", ram_wea, 16'h0000);
    chk("rst_ram_addra", ram_addra, 8'h00);
    chk("rst_ram_dina", ram_dina, '0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Basic burst write then read back, with first-beat latency.
    do_write(8'h10, 4'd3, 32'hD000_0000, 16'hFFFF, 8'h5A);
    p0 = pops;
    send_req(1'b0, 8'h10, 4'd3, 8'h5A);
    lat_armed = 1'b1;
    wait_idle();
    chk("t1_latency", lat_meas, 3);
    chk("t1_beats", pops - p0, 4);
    chk("t1_last_data", last_data, {4{32'hD000_0003}});
    chk("t1_last_flag", last_last, 1'b1);

    // Address wrap on write and read bursts.
    addr_log.delete();
    do_write(8'hFE, 4'd3, 32'h5EED_0000, 16'hFFFF, 8'h01);
    wait_idle();
    chk("t2_wr_log_len", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_wr_addr", addr_log[i], exp_a[i]);
    addr_log.delete();
    send_req(1'b0, 8'hFE, 4'd3, 8'h02);
    wait_idle();
    chk("t2_rd_log_len", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_rd_addr", addr_log[i], exp_a[i]);
    chk("t2_last_data", last_data, {4{32'h5EED_0003}});

    // Partial byte strobe.
    do_write(8'h20, 4'd0, 32'h1111_1111, 16'hFFFF, 8'h03);
    do_write(8'h20, 4'd0, 32'hAAAA_AAAA, 16'h000F, 8'h04);
    send_req(1'b0, 8'h20, 4'd0, 8'h05);
    wait_idle();
    chk("t3_partial", last_data, {{12{8'h11}}, {4{8'hAA}}});

    // Backpressure: credit caps issues at FIFO depth.
    rd_ready = 1'b0;
    issue_cnt = 0;
    send_req(1'b0, 8'h10, 4'd15, 8'h06);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t4_issues", issue_cnt, 4);
    chk("t4_ena_idle", ram_ena, 1'b0);
    chk("t4_rd_valid", rd_valid, 1'b1);
    @(posedge clk); #1;
    p0 = pops;
    rd_ready = 1'b1;
    wait_idle();
    chk("t4_beats", pops - p0, 16);

    // Read immediately followed by write to the same words.
    send_req(1'b0, 8'h10, 4'd1, 8'h07);
    do_write(8'h10, 4'd1, 32'hB2B0_0000, 16'hFFFF, 8'h08);
    wait_idle();
    chk("t5_old_data", last_data, {4{32'hD000_0001}});
    send_req(1'b0, 8'h10, 4'd1, 8'h09);
    wait_idle();
    chk("t5_new_data", last_data, {4{32'hB2B0_0001}});

    // Reset during the second beat of a 4-beat read.
    p0 = pops;
    send_req(1'b0, 8'h10, 4'd3, 8'h0A);
    n = 0;
    while (pops == p0 && n < 50) begin n++; @(posedge clk); end
    chk("t6_first_beat", pops - p0, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rd_valid", rd_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_req_ready", req_ready, 1'b1);
    chk("t6_ram_ena", ram_ena, 1'b0);
    @(posedge clk); #1;
    send_req(1'b0, 8'h11, 4'd0, 8'h0B);
    wait_idle();
    chk("t6_after_data", last_data, {4{32'hB2B0_0001}});
    chk("t6_after_last", last_last, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
